// File: rtl/xmailbox_pkg.sv
// Shared definitions for the mailbox: register offsets, STATUS layout, CTRL bits.
package xmailbox_pkg;

  // Register offsets on the 2-bit bus address.
  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_STAT = 2'd1,
    REG_CTRL = 2'd2,
    REG_RSVD = 2'd3
  } reg_addr_e;

  // CTRL write bit positions.
  localparam int unsigned CTRL_FLUSH_TX = 0;
  localparam int unsigned CTRL_FLUSH_RX = 1;

  // Width of each count field inside STATUS.
  localparam int unsigned STAT_COUNT_W = 8;
  localparam int unsigned STAT_W       = 24;

  // STATUS word, LSB last; zero-extended to the bus width on reads.
  typedef struct packed {
    logic [STAT_COUNT_W-1:0] tx_count;  // [23:16]
    logic [STAT_COUNT_W-1:0] rx_count;  // [15:8]
    logic [1:0]              rsvd;      // [7:6]
    logic                    rx_unf;    // [5]
    logic                    tx_ovf;    // [4]
    logic                    tx_full;   // [3]
    logic                    tx_empty;  // [2]
    logic                    rx_full;   // [1]
    logic                    rx_empty;  // [0]
  } status_t;

endpackage

// File: rtl/xmailbox_if.sv
// Mailbox connection bundle: core register bus plus TX/RX streaming handshakes.
//  master: core/agent side (drives bus requests, consumer ready, producer data)
//  slave : mailbox side (returns read data, TX head, RX ready)
interface xmailbox_if #(
  parameter int unsigned DATA_W = 32
);
  logic              sel;
  logic              we;
  logic [1:0]        addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (
    output sel, we, addr, data_in, tx_ready, rx_data, rx_valid,
    input  data_out, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  sel, we, addr, data_in, tx_ready, rx_data, rx_valid,
    output data_out, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/xmailbox_fifo.sv
// Synchronous register-array FIFO with first-word-fall-through head.
//  clk, rst  : clock, async active-high reset
//  flush     : zero pointers and count; a same-cycle push lands as sole entry
//  push, pop : requests, ignored when full / empty at cycle start
//  din, dout : write data, head word (0 when empty)
//  count     : occupancy; full/empty derive from it
module xmailbox_fifo #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;
  logic [PTR_W-1:0]  wr_idx;

  // Count is authoritative; pointers alone cannot tell full from empty.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // A push during flush lands in slot 0 so it becomes the only entry.
  assign wr_idx = flush ? '0 : wr_ptr;

  // Head is forced to 0 when empty so stale slots never leak out.
  assign dout = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are meaningless while count says empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_idx] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      if (push_ok) begin
        wr_ptr <= PTR_W'(1);
        count  <= CNT_W'(1);
      end else begin
        wr_ptr <= '0;
        count  <= '0;
      end
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/xmailbox.sv
// Memory-mapped mailbox: TX FIFO (core -> external consumer) and RX FIFO
// (external producer -> core) behind a zero-wait-state register bus.
//  clk, rst : clock, async active-high reset
//  bus      : xmailbox_if slave port
//             sel/we/addr/data_in/data_out  core register bus (read data combinational)
//             tx_data/tx_valid/tx_ready     TX stream toward consumer
//             rx_data/rx_valid/rx_ready     RX stream from producer
// DATA_W must be at least 24 so the STATUS word fits.
module xmailbox
  import xmailbox_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic      clk,
  input  logic      rst,
  xmailbox_if.slave bus
);

  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  reg_addr_e         reg_sel;
  logic              bus_rd;
  logic              bus_wr;
  logic              tx_push;
  logic              tx_pop;
  logic              tx_flush;
  logic              rx_push;
  logic              rx_pop;
  logic              rx_flush;
  logic              stat_rd;

  logic [DATA_W-1:0] tx_dout;
  logic [DATA_W-1:0] rx_dout;
  logic [CNT_W-1:0]  tx_count;
  logic [CNT_W-1:0]  rx_count;
  logic              tx_full;
  logic              tx_empty;
  logic              rx_full;
  logic              rx_empty;

  logic              tx_ovf;
  logic              rx_unf;
  status_t           status;

  // Bus decode.
  assign reg_sel  = reg_addr_e'(bus.addr);
  assign bus_rd   = bus.sel && !bus.we;
  assign bus_wr   = bus.sel && bus.we;
  assign tx_push  = bus_wr && (reg_sel == REG_DATA);
  assign rx_pop   = bus_rd && (reg_sel == REG_DATA);
  assign stat_rd  = bus_rd && (reg_sel == REG_STAT);
  assign tx_flush = bus_wr && (reg_sel == REG_CTRL) && bus.data_in[CTRL_FLUSH_TX];
  assign rx_flush = bus_wr && (reg_sel == REG_CTRL) && bus.data_in[CTRL_FLUSH_RX];

  // Stream handshakes.
  assign tx_pop       = bus.tx_valid && bus.tx_ready;
  assign rx_push      = bus.rx_valid && bus.rx_ready;
  assign bus.tx_valid = !tx_empty;
  assign bus.tx_data  = tx_dout;
  assign bus.rx_ready = !rx_full;

  xmailbox_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (tx_flush),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (bus.data_in),
    .dout  (tx_dout),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  xmailbox_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (rx_flush),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (bus.rx_data),
    .dout  (rx_dout),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // Sticky error flags; a new event beats a same-cycle clearing STATUS read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else begin
      if (tx_push && tx_full) begin
        tx_ovf <= 1'b1;
      end else if (stat_rd) begin
        tx_ovf <= 1'b0;
      end
      if (rx_pop && rx_empty) begin
        rx_unf <= 1'b1;
      end else if (stat_rd) begin
        rx_unf <= 1'b0;
      end
    end
  end

  // STATUS word assembly.
  always_comb begin
    status          = '0;
    status.rx_empty = rx_empty;
    status.rx_full  = rx_full;
    status.tx_empty = tx_empty;
    status.tx_full  = tx_full;
    status.tx_ovf   = tx_ovf;
    status.rx_unf   = rx_unf;
    status.rx_count = STAT_COUNT_W'(rx_count);
    status.tx_count = STAT_COUNT_W'(tx_count);
  end

  // Combinational read mux; an empty RX head already reads as 0.
  always_comb begin
    bus.data_out = '0;
    if (bus_rd) begin
      case (reg_sel)
        REG_DATA: bus.data_out = rx_dout;
        REG_STAT: bus.data_out = DATA_W'(status);
        default:  bus.data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_xmailbox.sv
// Self-checking bench for xmailbox using a queue-based reference model.
module tb_xmailbox;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  xmailbox_if #(.DATA_W(DW)) mb ();

  xmailbox #(
    .DATA_W     (DW),
    .DEPTH_LOG2 (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (mb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Reference model state.
  logic [DW-1:0] tx_q[$];
  logic [DW-1:0] rx_q[$];
  logic          m_ovf;
  logic          m_unf;

  // Per-step observations and model predictions.
  logic [DW-1:0] obs_rd, exp_rd, obs_txd, exp_txd;
  logic          obs_txv, exp_txv, obs_rrdy, exp_rrdy;

  function automatic logic [DW-1:0] model_status();
    logic [DW-1:0] r;
    r        = '0;
    r[0]     = (rx_q.size() == 0);
    r[1]     = (rx_q.size() == DEPTH);
    r[2]     = (tx_q.size() == 0);
    r[3]     = (tx_q.size() == DEPTH);
    r[4]     = m_ovf;
    r[5]     = m_unf;
    r[15:8]  = 8'(rx_q.size());
    r[23:16] = 8'(tx_q.size());
    return r;
  endfunction

  task automatic model_clear();
    tx_q.delete();
    rx_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One clock: drive inputs, sample outputs at negedge, advance the model at posedge.
  task automatic step(input logic s, input logic w, input logic [1:0] a, input logic [DW-1:0] d,
                      input logic trdy, input logic rvld, input logic [DW-1:0] rdat);
    bit tx_full_pre, rx_full_pre, rx_empty_pre;
    mb.sel = s; mb.we = w; mb.addr = a; mb.data_in = d;
    mb.tx_ready = trdy; mb.rx_valid = rvld; mb.rx_data = rdat;
    @(negedge clk);
    obs_rd   = mb.data_out;
    obs_txv  = mb.tx_valid;
    obs_txd  = mb.tx_data;
    obs_rrdy = mb.rx_ready;
    exp_txv  = (tx_q.size() != 0);
    exp_txd  = exp_txv ? tx_q[0] : '0;
    exp_rrdy = (rx_q.size() < DEPTH);
    exp_rd   = '0;
    if (s && !w) begin
      if (a == 2'd0)      exp_rd = (rx_q.size() != 0) ? rx_q[0] : '0;
      else if (a == 2'd1) exp_rd = model_status();
    end
    tx_full_pre  = (tx_q.size() == DEPTH);
    rx_full_pre  = (rx_q.size() == DEPTH);
    rx_empty_pre = (rx_q.size() == 0);
    // TX side
    if (s && w && a == 2'd2 && d[0]) begin
      tx_q.delete();
    end else begin
      if (trdy && tx_q.size() != 0) void'(tx_q.pop_front());
      if (s && w && a == 2'd0 && !tx_full_pre) tx_q.push_back(d);
    end
    // RX side: pop, then flush, then producer push
    if (s && !w && a == 2'd0 && !rx_empty_pre) void'(rx_q.pop_front());
    if (s && w && a == 2'd2 && d[1]) rx_q.delete();
    if (rvld && !rx_full_pre) rx_q.push_back(rdat);
    // Sticky flags
    if (s && w && a == 2'd0 && tx_full_pre) m_ovf = 1'b1;
    else if (s && !w && a == 2'd1)          m_ovf = 1'b0;
    if (s && !w && a == 2'd0 && rx_empty_pre) m_unf = 1'b1;
    else if (s && !w && a == 2'd1)            m_unf = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mb.sel = 1'b0; mb.we = 1'b0; mb.addr = 2'd0; mb.data_in = '0;
    mb.tx_ready = 1'b0; mb.rx_valid = 1'b0; mb.rx_data = '0;
    model_clear();
    #12;
    n_checks++; if (mb.tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %b want 0", mb.tx_valid); end
    n_checks++; if (mb.tx_data !== '0) begin n_fail++; $display("FAIL reset_tx_data got %h want 0", mb.tx_data); end
    n_checks++; if (mb.rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready got %b want 1", mb.rx_ready); end
    n_checks++; if (mb.data_out !== '0) begin n_fail++; $display("FAIL reset_data_out got %h want 0", mb.data_out); end
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b1, 1'b0, 2'd1, '0, 1'b0, 1'b0, '0);
    n_checks++; if (obs_rd !== 32'h0000_0005) begin n_fail++; $display("FAIL reset_status got %h want 00000005", obs_rd); end
  endtask

  task automatic test_tx_order();
    logic [DW-1:0] seq [3];
    seq[0] = 32'hA; seq[1] = 32'hB; seq[2] = 32'hC;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd0, seq[i], 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 2'd1, '0, 1'b0, 1'b0, '0);
    n_checks++; if (obs_rd[23:16] !== 8'd3) begin n_fail++; $display("FAIL tx_count got %0d want 3", obs_rd[23:16]); end
    n_checks++; if (obs_rd !== exp_rd) begin n_fail++; $display("FAIL tx_status got %h want %h", obs_rd, exp_rd); end
    n_checks++; if (obs_txd !== 32'hA) begin n_fail++; $display("FAIL tx_head got %h want 0000000a", obs_txd); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0, '0);
      n_checks++; if (obs_txv !== 1'b1 || obs_txd !== seq[i]) begin
        n_fail++; $display("FAIL tx_drain[%0d] got v=%b %h want v=1 %h", i, obs_txv, obs_txd, seq[i]);
      end
    end
    idle();
    n_checks++; if (obs_txv !== 1'b0) begin n_fail++; $display("FAIL tx_drained_valid got %b want 0", obs_txv); end
  endtask

  task automatic test_tx_overflow();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 2'd0, $urandom, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 2'd1, '0, 1'b0, 1'b0, '0);
    n_checks++; if (obs_rd[3] !== 1'b1 || obs_rd[4] !== 1'b1 || obs_rd[23:16] !== 8'd4) begin
      n_fail++; $display("FAIL ovf_status got %h want full=1 ovf=1 count=4", obs_rd);
    end
    n_checks++; if (obs_rd !== exp_rd) begin n_fail++; $display("FAIL ovf_model got %h want %h", obs_rd, exp_rd); end
    step(1'b1, 1'b0, 2'd1, '0, 1'b0, 1'b0, '0);
    n_checks++; if (obs_rd[4] !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", obs_rd[4]); end
    // Push while full with a concurrent consumer pop: still dropped.
    step(1'b1, 1'b1, 2'd0, 32'hDEAD_BEEF, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 2'd1, '0, 1'b0, 1'b0, '0);
    n_checks++; if (obs_rd[4] !== 1'b1 || obs_rd[23:16] !== 8'd3) begin
      n_fail++; $display("FAIL ovf_pop_same_cycle got %h want ovf=1 count=3", obs_rd);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0, '0);
      n_checks++; if (obs_txd !== exp_txd) begin n_fail++; $display("FAIL ovf_drain[%0d] got %h want %h", i, obs_txd, exp_txd); end
    end
    step(1'b1, 1'b0, 2'd1, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_rx_basic();
    step(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b1, 32'h11);
    step(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b1, 32'h22);
    step(1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b0, '0);
    n_checks++; if (obs_rd !== 32'h11) begin n_fail++; $display("FAIL rx_rd0 got %h want 00000011", obs_rd); end
    step(1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b0, '0);
    n_checks++; if (obs_rd !== 32'h22) begin n_fail++; $display("FAIL rx_rd1 got %h want 00000022", obs_rd); end
    step(1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b0, '0);
    n_checks++; if (obs_rd !== '0) begin n_fail++; $display("FAIL rx_rd_empty got %h want 0", obs_rd); end
    step(1'b1, 1'b0, 2'd1, '0, 1'b0, 1'b0, '0);
    n_checks++; if (obs_rd[5] !== 1'b1 || obs_rd[15:8] !== 8'd0) begin
      n_fail++; $display("FAIL rx_unf got %h want unf=1 count=0", obs_rd);
    end
  endtask

  task automatic test_rx_flush();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b1, $urandom);
    step(1'b1, 1'b1, 2'd2, 32'h2, 1'b0, 1'b1, 32'h77);
    step(1'b1, 1'b0, 2'd1, '0, 1'b0, 1'b0, '0);
    n_checks++; if (obs_rd[15:8] !== 8'd1) begin n_fail++; $display("FAIL rx_flush_count got %0d want 1", obs_rd[15:8]); end
    n_checks++; if (obs_rd !== exp_rd) begin n_fail++; $display("FAIL rx_flush_status got %h want %h", obs_rd, exp_rd); end
    step(1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b0, '0);
    n_checks++; if (obs_rd !== 32'h77) begin n_fail++; $display("FAIL rx_flush_data got %h want 00000077", obs_rd); end
  endtask

  task automatic test_random();
    logic s, w, trdy, rvld;
    logic [1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < 600; i++) begin
      s    = ($urandom_range(0, 3) != 0);
      w    = $urandom_range(0, 1) != 0;
      a    = 2'($urandom_range(0, 3));
      d    = $urandom;
      if (s && w && a == 2'd2) d = ($urandom_range(0, 5) == 0) ? DW'($urandom_range(0, 3)) : '0;
      trdy = ($urandom_range(0, 2) == 0);
      rvld = $urandom_range(0, 1) != 0;
      step(s, w, a, d, trdy, rvld, $urandom);
      n_checks++; if (obs_rd !== exp_rd) begin n_fail++; $display("FAIL rand_rd[%0d] got %h want %h", i, obs_rd, exp_rd); end
      n_checks++; if (obs_txv !== exp_txv || obs_txd !== exp_txd) begin
        n_fail++; $display("FAIL rand_tx[%0d] got v=%b %h want v=%b %h", i, obs_txv, obs_txd, exp_txv, exp_txd);
      end
      n_checks++; if (obs_rrdy !== exp_rrdy) begin n_fail++; $display("FAIL rand_rx_ready[%0d] got %b want %b", i, obs_rrdy, exp_rrdy); end
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b1, 2'd2, 32'h3, 1'b0, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 2'd0, $urandom, 1'b0, 1'b1, $urandom);
    idle();
    n_checks++; if (obs_rrdy !== 1'b0 || obs_txv !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset got rx_ready=%b tx_valid=%b want 0 1", obs_rrdy, obs_txv);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (mb.rx_ready !== 1'b1 || mb.tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got rx_ready=%b tx_valid=%b want 1 0", mb.rx_ready, mb.tx_valid);
    end
    mb.sel = 1'b1; mb.we = 1'b0; mb.addr = 2'd1;
    #1;
    n_checks++; if (mb.data_out !== 32'h0000_0005) begin n_fail++; $display("FAIL async_reset_status got %h want 00000005", mb.data_out); end
    mb.sel = 1'b0;
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b1, 1'b0, 2'd1, '0, 1'b0, 1'b0, '0);
    n_checks++; if (obs_rd !== exp_rd) begin n_fail++; $display("FAIL post_reset_status got %h want %h", obs_rd, exp_rd); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_tx_order();
    test_tx_overflow();
    test_rx_basic();
    test_rx_flush();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
